// File: rtl/pep_ks_boram_buffer.sv
// Body RAM between key-switch and bootstrap body consumer: two parity banks with
// per-entry valid bitmap, consume-on-accept reads and per-bank occupancy counters.
module pep_ks_boram_buffer #(
  parameter int DATA_W      = 21,
  parameter int PBS_NB      = 16,
  parameter int PID_W       = $clog2(PBS_NB),
  parameter int RAM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic                   ks_boram_wr_en,
  input  logic [DATA_W-1:0]      ks_boram_data,
  input  logic [PID_W-1:0]       ks_boram_pid,
  input  logic                   ks_boram_parity,
  input  logic                   rd_req_vld,
  output logic                   rd_req_rdy,
  input  logic [PID_W-1:0]       rd_req_pid,
  input  logic                   rd_req_parity,
  output logic                   rd_data_avail,
  output logic [DATA_W-1:0]      rd_data,
  output logic [PID_W-1:0]       rd_pid,
  input  logic                   reset_cache,
  output logic [1:0][PID_W:0]    bank_cnt,
  output logic                   err_overwrite,
  output logic                   err_pid
);

  localparam int ADDR_W = PID_W + 1;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [PID_W:0] PBS_NB_C = (PID_W + 1)'(PBS_NB);
  localparam logic [PID_W:0] CNT_ONE  = (PID_W + 1)'(1);

  logic [DEPTH-1:0]                   valid_r;
  logic [DATA_W-1:0]                  mem_r [DEPTH];
  logic [RAM_LATENCY-1:0]             pipe_vld_r;
  logic [RAM_LATENCY-1:0][DATA_W-1:0] pipe_data_r;
  logic [RAM_LATENCY-1:0][PID_W-1:0]  pipe_pid_r;
  logic                               err_overwrite_r;
  logic                               err_pid_r;

  logic              wr_pid_ok_s;
  logic              rd_pid_ok_s;
  logic              wr_ok_s;
  logic              acc_s;
  logic              same_s;
  logic              overwrite_s;
  logic              err_pid_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [1:0]        inc_s;
  logic [1:0]        dec_s;

  // Request decode: range checks, readiness, accept and per-bank count events
  always_comb begin
    wr_addr_s   = {ks_boram_parity, ks_boram_pid};
    rd_addr_s   = {rd_req_parity, rd_req_pid};
    wr_pid_ok_s = ({1'b0, ks_boram_pid} < PBS_NB_C);
    rd_pid_ok_s = ({1'b0, rd_req_pid} < PBS_NB_C);
    wr_ok_s     = ks_boram_wr_en & wr_pid_ok_s & ~reset_cache;
    rd_req_rdy  = valid_r[rd_addr_s] & ~reset_cache & rd_pid_ok_s;
    acc_s       = rd_req_vld & rd_req_rdy;
    // A write landing on the entry being consumed refills it rather than overwriting
    same_s      = acc_s & (rd_addr_s == wr_addr_s);
    overwrite_s = wr_ok_s & valid_r[wr_addr_s] & ~same_s;
    err_pid_s   = (ks_boram_wr_en & ~wr_pid_ok_s) | (rd_req_vld & ~rd_pid_ok_s);
    inc_s       = 2'b00;
    dec_s       = 2'b00;
    if (wr_ok_s) begin
      inc_s[ks_boram_parity] = ~valid_r[wr_addr_s] | same_s;
    end else begin
      inc_s = 2'b00;
    end
    if (acc_s) begin
      dec_s[rd_req_parity] = 1'b1;
    end else begin
      dec_s = 2'b00;
    end
  end

  // Body storage, no reset; read-before-write comes from the registered read port
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_addr_s] <= ks_boram_data;
    end
  end

  // Valid bitmap: clear on accept first so a same-entry write leaves it set
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      valid_r <= '0;
    end else if (reset_cache) begin
      valid_r <= '0;
    end else begin
      if (acc_s) begin
        valid_r[rd_addr_s] <= 1'b0;
      end
      if (wr_ok_s) begin
        valid_r[wr_addr_s] <= 1'b1;
      end
    end
  end

  // Per-bank occupancy, saturating at PBS_NB and never below zero
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      bank_cnt <= '0;
    end else if (reset_cache) begin
      bank_cnt <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        case ({inc_s[b], dec_s[b]})
          2'b10: begin
            if (bank_cnt[b] < PBS_NB_C) begin
              bank_cnt[b] <= bank_cnt[b] + CNT_ONE;
            end
          end
          2'b01: begin
            if (bank_cnt[b] != '0) begin
              bank_cnt[b] <= bank_cnt[b] - CNT_ONE;
            end
          end
          default: bank_cnt[b] <= bank_cnt[b];
        endcase
      end
    end
  end

  // Read pipeline; data stages only load on a valid beat so outputs hold between pulses
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      pipe_vld_r  <= '0;
      pipe_data_r <= '0;
      pipe_pid_r  <= '0;
    end else begin
      pipe_vld_r[0] <= acc_s;
      if (acc_s) begin
        pipe_data_r[0] <= mem_r[rd_addr_s];
        pipe_pid_r[0]  <= rd_req_pid;
      end
      for (int k = 1; k < RAM_LATENCY; k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        if (pipe_vld_r[k-1]) begin
          pipe_data_r[k] <= pipe_data_r[k-1];
          pipe_pid_r[k]  <= pipe_pid_r[k-1];
        end
      end
    end
  end

  // One-cycle error pulses
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      err_overwrite_r <= 1'b0;
      err_pid_r       <= 1'b0;
    end else begin
      err_overwrite_r <= overwrite_s;
      err_pid_r       <= err_pid_s;
    end
  end

  assign rd_data_avail = pipe_vld_r[RAM_LATENCY-1];
  assign rd_data       = pipe_data_r[RAM_LATENCY-1];
  assign rd_pid        = pipe_pid_r[RAM_LATENCY-1];
  assign err_overwrite = err_overwrite_r;
  assign err_pid       = err_pid_r;

endmodule

// File: tb/tb_pep_ks_boram_buffer.sv
// Directed bench: a 16-PID instance for the main function and a 12-PID instance for range errors.
module tb_pep_ks_boram_buffer;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;

  logic        wr_en = 1'b0, wr_par = 1'b0, vld = 1'b0, rpar = 1'b0, rcache = 1'b0;
  logic [20:0] wr_data = 21'h0;
  logic [3:0]  wr_pid = 4'h0, rpid = 4'h0;
  logic        rdy, avail, err_ow, err_pid;
  logic [20:0] rdata;
  logic [3:0]  rdpid;
  logic [1:0][4:0] cnt;

  logic        s_wr_en = 1'b0, s_wr_par = 1'b0, s_vld = 1'b0, s_rpar = 1'b0, s_rcache = 1'b0;
  logic [20:0] s_wr_data = 21'h0;
  logic [3:0]  s_wr_pid = 4'h0, s_rpid = 4'h0;
  logic        s_rdy, s_avail, s_err_ow, s_err_pid;
  logic [20:0] s_rdata;
  logic [3:0]  s_rdpid;
  logic [1:0][4:0] s_cnt;

  int checks = 0;
  int errors = 0;

  pep_ks_boram_buffer #(.DATA_W(21), .PBS_NB(16), .RAM_LATENCY(2)) u_dut (
    .clk(clk), .a_rst(a_rst),
    .ks_boram_wr_en(wr_en), .ks_boram_data(wr_data), .ks_boram_pid(wr_pid), .ks_boram_parity(wr_par),
    .rd_req_vld(vld), .rd_req_rdy(rdy), .rd_req_pid(rpid), .rd_req_parity(rpar),
    .rd_data_avail(avail), .rd_data(rdata), .rd_pid(rdpid),
    .reset_cache(rcache), .bank_cnt(cnt), .err_overwrite(err_ow), .err_pid(err_pid)
  );

  pep_ks_boram_buffer #(.DATA_W(21), .PBS_NB(12), .RAM_LATENCY(2)) u_dut12 (
    .clk(clk), .a_rst(a_rst),
    .ks_boram_wr_en(s_wr_en), .ks_boram_data(s_wr_data), .ks_boram_pid(s_wr_pid), .ks_boram_parity(s_wr_par),
    .rd_req_vld(s_vld), .rd_req_rdy(s_rdy), .rd_req_pid(s_rpid), .rd_req_parity(s_rpar),
    .rd_data_avail(s_avail), .rd_data(s_rdata), .rd_pid(s_rdpid),
    .reset_cache(s_rcache), .bank_cnt(s_cnt), .err_overwrite(s_err_ow), .err_pid(s_err_pid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr16(input logic [3:0] pid, input logic par, input logic [20:0] d);
    wr_en = 1'b1; wr_pid = pid; wr_par = par; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Accept a read and advance to the cycle where its data should be presented
  task automatic rd16(input logic [3:0] pid, input logic par);
    vld = 1'b1; rpid = pid; rpar = par;
    tick();
    vld = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #22 a_rst = 1'b0;
    tick();
    checks++; if ({rdy, avail, err_ow, err_pid} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rdy, avail, err_ow, err_pid}); end
    checks++; if ({rdata, rdpid} !== 25'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {rdata, rdpid}); end
    checks++; if (cnt !== 10'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cnt); end
    checks++; if ({s_rdy, s_avail, s_err_ow, s_err_pid, s_cnt} !== 14'h0) begin errors++; $display("FAIL reset_dut12 got %h exp 0", {s_rdy, s_avail, s_err_ow, s_err_pid, s_cnt}); end
  endtask

  task automatic test_basic();
    wr16(4'd3, 1'b0, 21'h1ABCD);
    vld = 1'b1; rpid = 4'd3; rpar = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy got %b exp 1", rdy); end
    checks++; if (cnt[0] !== 5'd1) begin errors++; $display("FAIL basic_cnt1 got %0d exp 1", cnt[0]); end
    tick();
    vld = 1'b0;
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL basic_early_avail got %b exp 0", avail); end
    checks++; if (cnt[0] !== 5'd0) begin errors++; $display("FAIL basic_cnt0 got %0d exp 0", cnt[0]); end
    tick();
    checks++; if ({avail, rdata, rdpid} !== {1'b1, 21'h1ABCD, 4'd3}) begin errors++; $display("FAIL basic_data got %b %h %0d exp 1 1abcd 3", avail, rdata, rdpid); end
    tick();
    checks++; if ({avail, rdata} !== {1'b0, 21'h1ABCD}) begin errors++; $display("FAIL basic_hold got %b %h exp 0 1abcd", avail, rdata); end
  endtask

  task automatic test_no_bypass();
    vld = 1'b1; rpid = 4'd5; rpar = 1'b1;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL nob_empty_rdy got %b exp 0", rdy); end
    tick();
    wr_en = 1'b1; wr_pid = 4'd5; wr_par = 1'b1; wr_data = 21'h01234;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL nob_bypass_rdy got %b exp 0", rdy); end
    tick();
    wr_en = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL nob_rdy_t1 got %b exp 1", rdy); end
    tick();
    vld = 1'b0;
    tick();
    checks++; if ({avail, rdata, rdpid} !== {1'b1, 21'h01234, 4'd5}) begin errors++; $display("FAIL nob_data got %b %h %0d exp 1 01234 5", avail, rdata, rdpid); end
    checks++; if (cnt[1] !== 5'd0) begin errors++; $display("FAIL nob_cnt got %0d exp 0", cnt[1]); end
  endtask

  task automatic test_fill_overwrite();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        wr16(4'(i), 1'(p), 21'h100 + 21'(p * 16 + i));
    checks++; if (cnt !== {5'd16, 5'd16}) begin errors++; $display("FAIL fill_cnt got %0d %0d exp 16 16", cnt[1], cnt[0]); end
    checks++; if (err_ow !== 1'b0) begin errors++; $display("FAIL fill_no_ow got %b exp 0", err_ow); end
    wr16(4'd0, 1'b0, 21'h0AAAA);
    checks++; if (err_ow !== 1'b1) begin errors++; $display("FAIL ow_pulse got %b exp 1", err_ow); end
    checks++; if (cnt[0] !== 5'd16) begin errors++; $display("FAIL ow_cnt got %0d exp 16", cnt[0]); end
    tick();
    checks++; if (err_ow !== 1'b0) begin errors++; $display("FAIL ow_one_cycle got %b exp 0", err_ow); end
    rd16(4'd0, 1'b0);
    checks++; if ({avail, rdata} !== {1'b1, 21'h0AAAA}) begin errors++; $display("FAIL ow_read got %b %h exp 1 0aaaa", avail, rdata); end
    checks++; if (cnt[0] !== 5'd15) begin errors++; $display("FAIL ow_read_cnt got %0d exp 15", cnt[0]); end
  endtask

  task automatic test_simul_rw();
    vld = 1'b1; rpid = 4'd7; rpar = 1'b0;
    wr_en = 1'b1; wr_pid = 4'd7; wr_par = 1'b0; wr_data = 21'h00005;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sim_rdy got %b exp 1", rdy); end
    tick();
    vld = 1'b0; wr_en = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sim_rdy_after got %b exp 1", rdy); end
    checks++; if ({err_ow, cnt[0]} !== {1'b0, 5'd15}) begin errors++; $display("FAIL sim_ow_cnt got %b %0d exp 0 15", err_ow, cnt[0]); end
    tick();
    checks++; if ({avail, rdata, rdpid} !== {1'b1, 21'h00107, 4'd7}) begin errors++; $display("FAIL sim_old_data got %b %h %0d exp 1 00107 7", avail, rdata, rdpid); end
    rd16(4'd7, 1'b0);
    checks++; if ({avail, rdata} !== {1'b1, 21'h00005}) begin errors++; $display("FAIL sim_new_data got %b %h exp 1 00005", avail, rdata); end
  endtask

  task automatic test_back_to_back();
    vld = 1'b1; rpid = 4'd1; rpar = 1'b0;
    tick();
    rpid = 4'd2;
    tick();
    vld = 1'b0;
    checks++; if ({avail, rdata, rdpid} !== {1'b1, 21'h00101, 4'd1}) begin errors++; $display("FAIL b2b_first got %b %h %0d exp 1 00101 1", avail, rdata, rdpid); end
    tick();
    checks++; if ({avail, rdata, rdpid} !== {1'b1, 21'h00102, 4'd2}) begin errors++; $display("FAIL b2b_second got %b %h %0d exp 1 00102 2", avail, rdata, rdpid); end
    tick();
    checks++; if ({avail, rdata} !== {1'b0, 21'h00102}) begin errors++; $display("FAIL b2b_hold got %b %h exp 0 00102", avail, rdata); end
    checks++; if (cnt[0] !== 5'd12) begin errors++; $display("FAIL b2b_cnt got %0d exp 12", cnt[0]); end
  endtask

  task automatic test_reset_cache();
    vld = 1'b1; rpid = 4'd3; rpar = 1'b0;
    tick();
    vld = 1'b0; rcache = 1'b1; rpid = 4'd4;
    wr_en = 1'b1; wr_pid = 4'd7; wr_par = 1'b0; wr_data = 21'h00077;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rc_rdy_forced got %b exp 0", rdy); end
    tick();
    rcache = 1'b0; wr_en = 1'b0;
    checks++; if ({avail, rdata, rdpid} !== {1'b1, 21'h00103, 4'd3}) begin errors++; $display("FAIL rc_inflight got %b %h %0d exp 1 00103 3", avail, rdata, rdpid); end
    checks++; if (cnt !== 10'h0) begin errors++; $display("FAIL rc_cnt got %0d %0d exp 0 0", cnt[1], cnt[0]); end
    for (int a = 0; a < 32; a++) begin
      rpar = 1'(a / 16); rpid = 4'(a % 16);
      #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rc_entry_%0d got %b exp 0", a, rdy); end
    end
  endtask

  task automatic test_err_pid();
    s_wr_en = 1'b1; s_wr_pid = 4'd13; s_wr_par = 1'b0; s_wr_data = 21'h00013;
    tick();
    s_wr_en = 1'b0;
    checks++; if ({s_err_pid, s_err_ow, s_cnt} !== {1'b1, 1'b0, 10'h0}) begin errors++; $display("FAIL ep_write got %b %b %h exp 1 0 0", s_err_pid, s_err_ow, s_cnt); end
    tick();
    checks++; if (s_err_pid !== 1'b0) begin errors++; $display("FAIL ep_one_cycle got %b exp 0", s_err_pid); end
    s_vld = 1'b1; s_rpid = 4'd13; s_rpar = 1'b0;
    #1;
    checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL ep_rdy got %b exp 0", s_rdy); end
    tick();
    checks++; if (s_err_pid !== 1'b1) begin errors++; $display("FAIL ep_vld1 got %b exp 1", s_err_pid); end
    tick();
    s_vld = 1'b0;
    checks++; if ({s_err_pid, s_avail} !== 2'b10) begin errors++; $display("FAIL ep_vld2 got %b exp 10", {s_err_pid, s_avail}); end
    tick();
    checks++; if (s_err_pid !== 1'b0) begin errors++; $display("FAIL ep_clear got %b exp 0", s_err_pid); end
    s_wr_en = 1'b1; s_wr_pid = 4'd11; s_wr_par = 1'b1;
    tick();
    s_wr_en = 1'b0; s_rpid = 4'd11; s_rpar = 1'b1;
    #1;
    checks++; if ({s_rdy, s_err_pid, s_cnt[1]} !== {1'b1, 1'b0, 5'd1}) begin errors++; $display("FAIL ep_pid11 got %b %b %0d exp 1 0 1", s_rdy, s_err_pid, s_cnt[1]); end
    s_rpid = 4'd12;
    #1;
    checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL ep_pid12_rdy got %b exp 0", s_rdy); end
  endtask

  task automatic test_async_reset();
    logic seen;
    wr16(4'd2, 1'b1, 21'h00222);
    vld = 1'b1; rpid = 4'd2; rpar = 1'b1;
    tick();
    vld = 1'b0;
    #2 a_rst = 1'b1;
    #2 a_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (avail) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ar_avail got %b exp 0", seen); end
    checks++; if ({rdata, cnt, s_cnt} !== 41'h0) begin errors++; $display("FAIL ar_state got %h exp 0", {rdata, cnt, s_cnt}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_bypass();
    test_fill_overwrite();
    test_simul_rw();
    test_back_to_back();
    test_reset_cache();
    test_err_pid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
